// File: rtl/plab5_mcore_mem_net_resp_serializer_if.sv
// plab5_mcore_mem_net_resp_serializer_if: val/rdy message channel with split control, data and domain
interface plab5_mcore_mem_net_resp_serializer_if #(
  parameter int p_ctrl_nbits = 1,
  parameter int p_data_nbits = 1
);
  logic                    val;
  logic                    rdy;
  logic                    domain;
  logic [p_ctrl_nbits-1:0] control;
  logic [p_data_nbits-1:0] data;
  modport master(output val, domain, control, data, input rdy);
  modport slave(input val, domain, control, data, output rdy);
endinterface

// File: rtl/plab5_mcore_mem_net_resp_serializer.sv
// plab5_mcore_mem_net_resp_serializer: serialises one cacheline memory response into single-word network flits
module plab5_mcore_mem_net_resp_serializer #(
  parameter int p_net_src           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_cacheline_nwords  = 4,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_len_nbits         = 2
)(
  input logic clk,
  input logic reset,
  input logic mode,
  plab5_mcore_mem_net_resp_serializer_if.slave  mem,
  plab5_mcore_mem_net_resp_serializer_if.master net
);
  localparam int mo = p_mem_opaque_nbits;
  localparam int md = p_mem_data_nbits;
  localparam int nw = p_cacheline_nwords;
  localparam int no = p_net_opaque_nbits;
  localparam int ns = p_net_srcdest_nbits;
  localparam int ln = p_len_nbits;
  localparam int cc = 3 + mo + ln;
  localparam int dw = nw * md;
  localparam int iw = $clog2(nw);
  localparam logic [ns-1:0] src = ns'(p_net_src);
  if (nw < 2 || (nw & (nw - 1)) != 0) begin : g_bad_nwords
    $error("cacheline word count must be a power of two, at least 2");
  end
  if (no < iw + 1) begin : g_bad_net_opaque
    $error("network opaque too narrow for {last, idx}");
  end
  if (p_num_ports > (1 << ns)) begin : g_bad_ports
    $error("src/dest field too narrow for port count");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t        state;
  logic [iw-1:0] idx;
  logic [cc-1:0] ctrl_r;
  logic [dw-1:0] data_r;
  logic          dom_r;
  logic          mode_r;
  logic          is_read;
  logic          last;
  logic          adv;
  logic          acc;
  logic [ns-1:0] dest;
  logic [no-1:0] net_opq;
  // Only reads carry a cacheline; every other response is a single dataless flit
  assign is_read  = ctrl_r[cc-1 -: 3] == 3'd0;
  assign last     = !is_read || idx == iw'(nw - 1);
  assign adv      = state == SEND && net.rdy;
  assign mem.rdy  = state == IDLE || (adv && last);
  assign acc      = mem.val && mem.rdy;
  assign dest     = mode_r ? '0 : ctrl_r[ln+mo-1 -: ns];
  // Sequence tag: last flag in the MSB, word index zero-extended below it
  always_comb begin
    net_opq = '0;
    net_opq[iw-1:0] = idx;
    net_opq[no-1] = last;
  end
  assign net.val     = state == SEND;
  assign net.domain  = dom_r;
  assign net.control = {dest, src, net_opq, ctrl_r};
  assign net.data    = is_read ? data_r[idx*md +: md] : '0;
  // Message FSM: latch on accept, step idx per flit handshake, reload on last-flit overlap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      ctrl_r <= '0;
      data_r <= '0;
      dom_r  <= 1'b0;
      mode_r <= 1'b0;
    end else if (acc) begin
      state  <= SEND;
      idx    <= '0;
      ctrl_r <= mem.control;
      data_r <= mem.data;
      dom_r  <= mem.domain;
      mode_r <= mode;
    end else if (adv) begin
      state <= last ? IDLE : SEND;
      idx   <= last ? idx : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_plab5_mcore_mem_net_resp_serializer.sv
// tb_plab5_mcore_mem_net_resp_serializer: directed self-checking bench for the response serializer
module tb_plab5_mcore_mem_net_resp_serializer;
  int checks = 0;
  int fails = 0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic [127:0] line_a = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  logic [127:0] line_b = {32'h44440013, 32'h33330012, 32'h22220011, 32'h11110010};
  always #5 clk = ~clk;
  plab5_mcore_mem_net_resp_serializer_if #(.p_ctrl_nbits(13), .p_data_nbits(128)) mem_if();
  plab5_mcore_mem_net_resp_serializer_if #(.p_ctrl_nbits(23), .p_data_nbits(32)) net_if();
  plab5_mcore_mem_net_resp_serializer dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .mem(mem_if),
    .net(net_if)
  );
  function automatic logic [22:0] exp_ctrl(input logic [2:0] dst, input logic [3:0] nop,
                                           input logic [2:0] t, input logic [7:0] op, input logic [1:0] ln);
    return {dst, 3'd0, nop, t, op, ln};
  endfunction
  task automatic test_reset();
    mem_if.val = 0; mem_if.domain = 0; mem_if.control = '0; mem_if.data = '0; net_if.rdy = 1;
    @(negedge clk);
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL reset out_val got %b exp 0", net_if.val); end
    checks++; if (mem_if.rdy !== 1'b1) begin fails++; $display("FAIL reset in_rdy got %b exp 1", mem_if.rdy); end
    checks++; if (net_if.domain !== 1'b0) begin fails++; $display("FAIL reset out_domain got %b exp 0", net_if.domain); end
    checks++; if (net_if.control !== 23'd0) begin fails++; $display("FAIL reset ctrl got %h exp 0", net_if.control); end
    checks++; if (net_if.data !== 32'd0) begin fails++; $display("FAIL reset data got %h exp 0", net_if.data); end
    reset = 0;
  endtask
  task automatic test_read();
    logic [3:0] nop;
    @(negedge clk);
    net_if.rdy = 1; mode = 0; mem_if.domain = 0;
    mem_if.control = {3'd0, 8'hA5, 2'd3}; mem_if.data = line_a; mem_if.val = 1;
    #1;
    checks++; if (mem_if.rdy !== 1'b1) begin fails++; $display("FAIL read accept in_rdy got %b exp 1", mem_if.rdy); end
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL read accept out_val got %b exp 0", net_if.val); end
    @(negedge clk);
    mem_if.val = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      nop = (k == 3) ? 4'hB : 4'(k);
      checks++; if (net_if.val !== 1'b1) begin fails++; $display("FAIL read flit%0d out_val got %b exp 1", k, net_if.val); end
      checks++; if (net_if.control !== exp_ctrl(3'd5, nop, 3'd0, 8'hA5, 2'd3)) begin fails++; $display("FAIL read flit%0d ctrl got %h exp %h", k, net_if.control, exp_ctrl(3'd5, nop, 3'd0, 8'hA5, 2'd3)); end
      checks++; if (net_if.data !== line_a[k*32 +: 32]) begin fails++; $display("FAIL read flit%0d data got %h exp %h", k, net_if.data, line_a[k*32 +: 32]); end
      checks++; if (mem_if.rdy !== (k == 3)) begin fails++; $display("FAIL read flit%0d in_rdy got %b exp %b", k, mem_if.rdy, k == 3); end
      @(negedge clk);
    end
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL read drained out_val got %b exp 0", net_if.val); end
  endtask
  task automatic test_write_ack();
    @(negedge clk);
    net_if.rdy = 1; mode = 0; mem_if.domain = 0;
    mem_if.control = {3'd1, 8'h40, 2'd0}; mem_if.data = line_b; mem_if.val = 1;
    @(negedge clk);
    mem_if.val = 0;
    #1;
    checks++; if (net_if.val !== 1'b1) begin fails++; $display("FAIL wack out_val got %b exp 1", net_if.val); end
    checks++; if (net_if.control !== exp_ctrl(3'd2, 4'h8, 3'd1, 8'h40, 2'd0)) begin fails++; $display("FAIL wack ctrl got %h exp %h", net_if.control, exp_ctrl(3'd2, 4'h8, 3'd1, 8'h40, 2'd0)); end
    checks++; if (net_if.data !== 32'd0) begin fails++; $display("FAIL wack data got %h exp 0", net_if.data); end
    checks++; if (mem_if.rdy !== 1'b1) begin fails++; $display("FAIL wack in_rdy got %b exp 1", mem_if.rdy); end
    @(negedge clk);
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL wack single flit out_val got %b exp 0", net_if.val); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] nop;
    logic [22:0] ec;
    logic [31:0] ed;
    @(negedge clk);
    net_if.rdy = 1; mode = 0; mem_if.domain = 0;
    mem_if.control = {3'd0, 8'h20, 2'd0}; mem_if.data = line_a; mem_if.val = 1;
    @(negedge clk);
    mem_if.control = {3'd0, 8'hE7, 2'd2}; mem_if.data = line_b;
    for (int i = 0; i < 8; i++) begin
      #1;
      nop = ((i % 4) == 3) ? 4'hB : 4'(i % 4);
      ec = (i < 4) ? exp_ctrl(3'd1, nop, 3'd0, 8'h20, 2'd0) : exp_ctrl(3'd7, nop, 3'd0, 8'hE7, 2'd2);
      ed = (i < 4) ? line_a[i*32 +: 32] : line_b[(i-4)*32 +: 32];
      checks++; if (net_if.val !== 1'b1) begin fails++; $display("FAIL b2b flit%0d out_val got %b exp 1", i, net_if.val); end
      checks++; if (net_if.control !== ec) begin fails++; $display("FAIL b2b flit%0d ctrl got %h exp %h", i, net_if.control, ec); end
      checks++; if (net_if.data !== ed) begin fails++; $display("FAIL b2b flit%0d data got %h exp %h", i, net_if.data, ed); end
      checks++; if (mem_if.rdy !== (i == 3 || i == 7)) begin fails++; $display("FAIL b2b flit%0d in_rdy got %b exp %b", i, mem_if.rdy, i == 3 || i == 7); end
      @(negedge clk);
      if (i == 3) mem_if.val = 0;
    end
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL b2b drained out_val got %b exp 0", net_if.val); end
  endtask
  task automatic test_backpressure();
    logic pat [16] = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] nop;
    int e = 0;
    int c = 0;
    @(negedge clk);
    net_if.rdy = 1; mode = 0; mem_if.domain = 1;
    mem_if.control = {3'd0, 8'hC3, 2'd1}; mem_if.data = line_b; mem_if.val = 1;
    @(negedge clk);
    mem_if.val = 0;
    while (e < 4 && c < 16) begin
      net_if.rdy = pat[c];
      if (c == 2) mem_if.domain = 0;
      #1;
      nop = (e == 3) ? 4'hB : 4'(e);
      checks++; if (net_if.val !== 1'b1) begin fails++; $display("FAIL bp cyc%0d out_val got %b exp 1", c, net_if.val); end
      checks++; if (net_if.control !== exp_ctrl(3'd6, nop, 3'd0, 8'hC3, 2'd1)) begin fails++; $display("FAIL bp cyc%0d ctrl got %h exp %h", c, net_if.control, exp_ctrl(3'd6, nop, 3'd0, 8'hC3, 2'd1)); end
      checks++; if (net_if.data !== line_b[e*32 +: 32]) begin fails++; $display("FAIL bp cyc%0d data got %h exp %h", c, net_if.data, line_b[e*32 +: 32]); end
      checks++; if (net_if.domain !== 1'b1) begin fails++; $display("FAIL bp cyc%0d out_domain got %b exp 1", c, net_if.domain); end
      if (pat[c]) e++;
      c++;
      @(negedge clk);
    end
    checks++; if (c !== 9) begin fails++; $display("FAIL bp cycle count got %0d exp 9", c); end
    net_if.rdy = 1;
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL bp drained out_val got %b exp 0", net_if.val); end
  endtask
  task automatic test_mode_domain();
    logic [3:0] nop;
    @(negedge clk);
    net_if.rdy = 1; mode = 1; mem_if.domain = 1;
    mem_if.control = {3'd0, 8'hA5, 2'd1}; mem_if.data = line_a; mem_if.val = 1;
    @(negedge clk);
    mem_if.val = 0; mode = 0; mem_if.domain = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      nop = (k == 3) ? 4'hB : 4'(k);
      checks++; if (net_if.control !== exp_ctrl(3'd0, nop, 3'd0, 8'hA5, 2'd1)) begin fails++; $display("FAIL mode flit%0d ctrl got %h exp %h", k, net_if.control, exp_ctrl(3'd0, nop, 3'd0, 8'hA5, 2'd1)); end
      checks++; if (net_if.domain !== 1'b1) begin fails++; $display("FAIL mode flit%0d out_domain got %b exp 1", k, net_if.domain); end
      checks++; if (net_if.data !== line_a[k*32 +: 32]) begin fails++; $display("FAIL mode flit%0d data got %h exp %h", k, net_if.data, line_a[k*32 +: 32]); end
      @(negedge clk);
    end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    net_if.rdy = 1; mode = 0; mem_if.domain = 1;
    mem_if.control = {3'd0, 8'h60, 2'd2}; mem_if.data = line_a; mem_if.val = 1;
    @(negedge clk);
    mem_if.val = 0;
    @(negedge clk);
    #1;
    checks++; if (net_if.control !== exp_ctrl(3'd3, 4'h1, 3'd0, 8'h60, 2'd2)) begin fails++; $display("FAIL arst flit1 ctrl got %h exp %h", net_if.control, exp_ctrl(3'd3, 4'h1, 3'd0, 8'h60, 2'd2)); end
    #1 reset = 1;
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL arst out_val got %b exp 0", net_if.val); end
    checks++; if (mem_if.rdy !== 1'b1) begin fails++; $display("FAIL arst in_rdy got %b exp 1", mem_if.rdy); end
    checks++; if (net_if.domain !== 1'b0) begin fails++; $display("FAIL arst out_domain got %b exp 0", net_if.domain); end
    @(negedge clk);
    reset = 0;
    mem_if.domain = 0; mem_if.control = {3'd0, 8'h60, 2'd2}; mem_if.data = line_a; mem_if.val = 1;
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL arst held out_val got %b exp 0", net_if.val); end
    @(negedge clk);
    mem_if.val = 0;
    #1;
    checks++; if (net_if.control !== exp_ctrl(3'd3, 4'h0, 3'd0, 8'h60, 2'd2)) begin fails++; $display("FAIL arst restart ctrl got %h exp %h", net_if.control, exp_ctrl(3'd3, 4'h0, 3'd0, 8'h60, 2'd2)); end
    checks++; if (net_if.data !== line_a[31:0]) begin fails++; $display("FAIL arst restart data got %h exp %h", net_if.data, line_a[31:0]); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (net_if.val !== 1'b0) begin fails++; $display("FAIL arst drained out_val got %b exp 0", net_if.val); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write_ack();
    test_back_to_back();
    test_backpressure();
    test_mode_domain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
